// File: rtl/vga_sync_gen.sv
// VGA scan timing: divides clk into a pixel tick, runs the column/line counters
// and produces registered hsync/vsync/video_on aligned with pix_x/pix_y.
module vga_sync_gen #(
  parameter int DIV = 2,
  parameter int HD  = 640,
  parameter int HF  = 16,
  parameter int HR  = 96,
  parameter int HB  = 48,
  parameter int VD  = 480,
  parameter int VF  = 10,
  parameter int VR  = 2,
  parameter int VB  = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  output logic       pixel_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;

  if (HT > 1023 || VT > 1023) begin : g_bad_total
    $error("vga_sync_gen: HT=%0d / VT=%0d exceed the 10-bit counter range", HT, VT);
  end
  if (DIV < 1 || DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: DIV=%0d outside 1..16", DIV);
  end

  localparam logic [3:0] DIV_LAST     = 4'(DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(HT - 1);
  localparam logic [9:0] V_LAST       = 10'(VT - 1);
  localparam logic [9:0] H_VIS        = 10'(HD);
  localparam logic [9:0] V_VIS        = 10'(VD);
  localparam logic [9:0] H_SYNC_START = 10'(HD + HF);
  localparam logic [9:0] H_SYNC_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] V_SYNC_START = 10'(VD + VF);
  localparam logic [9:0] V_SYNC_END   = 10'(VD + VF + VR - 1);

  function automatic logic hsync_level(input logic [9:0] x);
    return !(x >= H_SYNC_START && x <= H_SYNC_END);
  endfunction

  function automatic logic vsync_level(input logic [9:0] y);
    return !(y >= V_SYNC_START && y <= V_SYNC_END);
  endfunction

  function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
    return (x < H_VIS) && (y < V_VIS);
  endfunction

  logic [3:0] div_cnt;
  logic       adv;
  logic       at_frame_end;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  assign adv          = ce & pixel_tick;
  assign at_frame_end = (pix_x == H_LAST) && (pix_y == V_LAST);

  // Next-state scan position; wraps by explicit compare, never by overflow.
  always_comb begin
    x_nxt = pix_x;
    y_nxt = pix_y;
    if (adv) begin
      if (pix_x == H_LAST) begin
        x_nxt = 10'd0;
        y_nxt = (pix_y == V_LAST) ? 10'd0 : pix_y + 10'd1;
      end else begin
        x_nxt = pix_x + 10'd1;
      end
    end
  end

  // Divider and scan registers; sync/blank are derived from the next-state
  // position so they switch on the same edge as pix_x/pix_y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= 4'd0;
      pixel_tick <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else if (ce) begin
      div_cnt    <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      pixel_tick <= (div_cnt == DIV_LAST);
      frame_tick <= adv && at_frame_end;
      if (adv) begin
        pix_x    <= x_nxt;
        pix_y    <= y_nxt;
        hsync    <= hsync_level(x_nxt);
        vsync    <= vsync_level(y_nxt);
        video_on <= visible(x_nxt, y_nxt);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (640x480/DIV=2, small/DIV=3, small/DIV=1)
// compared every cycle against a closed-form model driven by the enabled-clock count.
module tb_vga_sync_gen;

  localparam int SHD = 16, SHF = 4, SHR = 6, SHB = 4;
  localparam int SVD = 10, SVF = 2, SVR = 2, SVB = 3;
  localparam logic [24:0] RESET_V = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, rst2_n;
  logic ce0, ce1, ce2;
  logic tick0, tick1, tick2;
  logic [9:0] x0, x1, x2, y0, y1, y2;
  logic hs0, hs1, hs2, vs0, vs1, vs2, vo0, vo1, vo2, ft0, ft1, ft2;

  int n_pass = 0;
  int n_total = 0;

  vga_sync_gen #(.DIV(2)) u_dut (
    .clk(clk), .reset_n(rst0_n), .ce(ce0), .pixel_tick(tick0), .pix_x(x0), .pix_y(y0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .frame_tick(ft0));

  vga_sync_gen #(.DIV(3), .HD(SHD), .HF(SHF), .HR(SHR), .HB(SHB),
                 .VD(SVD), .VF(SVF), .VR(SVR), .VB(SVB)) u_small (
    .clk(clk), .reset_n(rst1_n), .ce(ce1), .pixel_tick(tick1), .pix_x(x1), .pix_y(y1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .frame_tick(ft1));

  vga_sync_gen #(.DIV(1), .HD(SHD), .HF(SHF), .HR(SHR), .HB(SHB),
                 .VD(SVD), .VF(SVF), .VR(SVR), .VB(SVB)) u_div1 (
    .clk(clk), .reset_n(rst2_n), .ce(ce2), .pixel_tick(tick2), .pix_x(x2), .pix_y(y2),
    .hsync(hs2), .vsync(vs2), .video_on(vo2), .frame_tick(ft2));

  logic [24:0] obs [3];
  assign obs[0] = {tick0, x0, y0, hs0, vs0, vo0, ft0};
  assign obs[1] = {tick1, x1, y1, hs1, vs1, vo1, ft1};
  assign obs[2] = {tick2, x2, y2, hs2, vs2, vo2, ft2};

  // Reference: every output is a pure function of e = enabled clk edges since reset.
  // The pixel tick is high after edge e when e is a multiple of DIV; edge e
  // advances the scan when the tick was high before it, so position = (e-1)/DIV.
  function automatic logic [24:0] model(input int e, input int div,
                                        input int hd, input int hf, input int hr, input int hb,
                                        input int vd, input int vf, input int vr, input int vb);
    int ht, vt, p, x, y;
    logic tk, hs, vs, vo, ft;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    tk = (e >= 1) && (e % div == 0);
    p  = (e >= 1) ? (e - 1) / div : 0;
    x  = p % ht;
    y  = (p / ht) % vt;
    vo = (p > 0) && (x < hd) && (y < vd);
    hs = !(x >= hd + hf && x < hd + hf + hr);
    vs = !(y >= vd + vf && y < vd + vf + vr);
    ft = (e >= 2) && ((e - 1) % div == 0) && (p % (ht * vt) == 0);
    return {tk, 10'(x), 10'(y), hs, vs, vo, ft};
  endfunction

  int e0 = 0, e1 = 0, e2 = 0;
  always @(posedge clk or negedge rst0_n) if (!rst0_n) e0 <= 0; else if (ce0) e0 <= e0 + 1;
  always @(posedge clk or negedge rst1_n) if (!rst1_n) e1 <= 0; else if (ce1) e1 <= e1 + 1;
  always @(posedge clk or negedge rst2_n) if (!rst2_n) e2 <= 0; else if (ce2) e2 <= e2 + 1;

  logic [24:0] exp_v [3];
  always_comb begin
    exp_v[0] = model(e0, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    exp_v[1] = model(e1, 3, SHD, SHF, SHR, SHB, SVD, SVF, SVR, SVB);
    exp_v[2] = model(e2, 1, SHD, SHF, SHR, SHB, SVD, SVF, SVR, SVB);
  end

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (obs[k] !== RESET_V) $display("FAIL reset_state[%0d] got=%h want=%h", k, obs[k], RESET_V);
        else n_pass++;
      end
    end
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (tick0 !== 1'b0) $display("FAIL first_tick_clk1 got=%b want=0", tick0); else n_pass++;
    @(negedge clk);
    n_total++;
    if (tick0 !== 1'b1) $display("FAIL first_tick_clk2 got=%b want=1", tick0); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({x0, y0, vo0, hs0, vs0} !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL first_advance got x=%0d y=%0d vo=%b hs=%b vs=%b want x=1 y=0 vo=1 hs=1 vs=1",
               x0, y0, vo0, hs0, vs0);
    else n_pass++;
  endtask

  task automatic test_line();
    int hs_ticks = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[0] !== exp_v[0]) $display("FAIL line_scan t=%0t got=%h want=%h", $time, obs[0], exp_v[0]);
      else n_pass++;
      if (tick0 === 1'b1 && hs0 === 1'b0) hs_ticks++;
    end
    n_total++;
    if (hs_ticks != 192) $display("FAIL hsync_low_ticks got=%0d want=192", hs_ticks);
    else n_pass++;
  endtask

  task automatic test_ce_freeze();
    bit found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[0] !== exp_v[0]) $display("FAIL freeze_approach got=%h want=%h", obs[0], exp_v[0]);
      else n_pass++;
      if (exp_v[0][23:14] == 10'd655) found = 1;
    end
    n_total++;
    if (!found) begin
      $display("FAIL freeze_reach_655 got=timeout want=pix_x 655");
      return;
    end
    n_pass++;
    ce0 = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[0] !== exp_v[0]) $display("FAIL freeze_hold got=%h want=%h", obs[0], exp_v[0]);
      else n_pass++;
    end
    ce0 = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[0] !== exp_v[0]) $display("FAIL freeze_resume got=%h want=%h", obs[0], exp_v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    int ft_cnt = 0;
    rst1_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst1_n = 1'b1;
    for (int i = 0; i < 3120; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[1] !== exp_v[1]) $display("FAIL frame_scan t=%0t got=%h want=%h", $time, obs[1], exp_v[1]);
      else n_pass++;
      if (ft1 === 1'b1) begin
        ft_cnt++;
        n_total++;
        if ({x1, y1} !== 20'd0) $display("FAIL frame_tick_pos got x=%0d y=%0d want 0,0", x1, y1);
        else n_pass++;
      end
    end
    n_total++;
    if (ft_cnt != 2) $display("FAIL frame_tick_count got=%0d want=2", ft_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (exp_v[1][23:14] == 10'd5 && exp_v[1][13:4] == 10'd9) found = 1;
    end
    n_total++;
    if (!found) begin
      $display("FAIL midreset_reach got=timeout want=pix 5,9");
      return;
    end
    n_pass++;
    n_total++;
    if (obs[1] === RESET_V) $display("FAIL midreset_pre got=%h want=non-reset state", obs[1]);
    else n_pass++;
    @(posedge clk);
    #2 rst1_n = 1'b0;
    #1;
    n_total++;
    if (obs[1] !== RESET_V) $display("FAIL midreset_async got=%h want=%h", obs[1], RESET_V);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst1_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[1] !== exp_v[1]) $display("FAIL midreset_restart got=%h want=%h", obs[1], exp_v[1]);
      else n_pass++;
    end
  endtask

  task automatic test_div1();
    int ft_cnt = 0;
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 1050; i++) begin
      @(negedge clk);
      n_total++;
      if (obs[2] !== exp_v[2]) $display("FAIL div1_scan t=%0t got=%h want=%h", $time, obs[2], exp_v[2]);
      else n_pass++;
      if (ft2 === 1'b1) ft_cnt++;
    end
    n_total++;
    if (ft_cnt != 2) $display("FAIL div1_frame_count got=%0d want=2", ft_cnt); else n_pass++;
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (obs[k] !== exp_v[k]) $display("FAIL random_ce[%0d] got=%h want=%h", k, obs[k], exp_v[k]);
        else n_pass++;
      end
      ce0 = ($urandom_range(0, 3) != 0);
      ce1 = ($urandom_range(0, 3) != 0);
      ce2 = ($urandom_range(0, 3) != 0);
    end
    ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1;
  endtask

  initial begin
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1;
    #1;
    test_reset();
    test_line();
    test_ce_freeze();
    test_frame();
    test_reset_mid();
    test_div1();
    test_random_ce();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
